// File: rtl/chrono_ctrl_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding, button
// indices and the frozen-display record.
package chrono_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STOP    = 3'd2,
        LAP     = 3'd3,
        LAPSTOP = 3'd4
    } state_t;

    localparam int NUM_BTN = 2;
    localparam int BTN_SS  = 0;
    localparam int BTN_LR  = 1;

    // d3..d0 = tens of seconds, seconds, tenths, hundredths
    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } disp_t;

    function automatic logic frozen(input state_t s);
        return (s == LAP) || (s == LAPSTOP);
    endfunction

endpackage

// File: rtl/chrono_ctrl_edge_det.sv
// Synchronous rising-edge detector; the history bit resets high so a button
// held through reset does not register as a press.
module chrono_ctrl_edge_det (
    input  logic ck,
    input  logic cl,
    input  logic d,
    output logic p
);

    logic q;

    always_ff @(posedge ck) begin
        if (cl) q <= 1'b1;
        else    q <= d;
    end

    assign p = d & ~q;

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch control FSM: start/stop and lap/reset buttons drive the datapath
// enable/clear and a display register that can be frozen for lap times.
module chrono_ctrl
    import chrono_ctrl_pkg::*;
#(
    parameter bit LAP_EN = 1'b1
) (
    input  logic       ck,
    input  logic       cl,
    input  logic       ss,
    input  logic       lr,
    input  logic [3:0] c0,
    input  logic [3:0] c1,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic       run,
    output logic       clr,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       lap
);

    logic [NUM_BTN-1:0] btn, press;
    state_t             state, nxt;
    disp_t              disp;

    assign btn = {lr, ss};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        chrono_ctrl_edge_det u_ed (
            .ck (ck),
            .cl (cl),
            .d  (btn[i]),
            .p  (press[i])
        );
    end

    // start/stop wins when both buttons rise together
    always_comb begin
        nxt = state;
        if (press[BTN_SS]) begin
            case (state)
                IDLE:    nxt = RUN;
                RUN:     nxt = STOP;
                LAP:     nxt = LAPSTOP;
                LAPSTOP: nxt = LAP;
                STOP:    nxt = RUN;
                default: nxt = IDLE;
            endcase
        end else if (press[BTN_LR]) begin
            case (state)
                RUN:     nxt = LAP_EN ? LAP : RUN;
                LAP:     nxt = RUN;
                LAPSTOP: nxt = STOP;
                STOP:    nxt = IDLE;
                IDLE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (cl) begin
            state <= IDLE;
            run   <= 1'b0;
            clr   <= 1'b1;
            lap   <= 1'b0;
            disp  <= '0;
        end else begin
            state <= nxt;
            run   <= (nxt == RUN) || (nxt == LAP);
            clr   <= (nxt == IDLE);
            lap   <= frozen(nxt);
            // gated on the current state, so the edge entering a frozen state still captures
            if (!frozen(state)) disp <= {s1, s0, c1, c0};
        end
    end

    assign d0 = disp.d0;
    assign d1 = disp.d1;
    assign d2 = disp.d2;
    assign d3 = disp.d3;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Bench for chrono_ctrl: one instance with lap enabled and one without,
// driven by directed scenarios then random presses, checked against a model.
module tb_chrono_ctrl;

    logic ck = 1'b0;
    logic cl = 1'b1, ss = 1'b0, lr = 1'b0;
    logic [3:0] c0 = '0, c1 = '0, s0 = '0, s1 = '0;

    logic [1:0]       run, clr, lap;
    logic [1:0][15:0] dsp;

    int checks = 0;
    int errors = 0;

    // model: counting / frozen / idle flags instead of a state number
    bit          m_idle[2], m_cnt[2], m_frz[2];
    logic [15:0] m_disp[2];
    logic        m_ssq = 1'b1, m_lrq = 1'b1;

    always #5 ck = ~ck;

    chrono_ctrl #(.LAP_EN(1'b1)) dut (
        .ck(ck), .cl(cl), .ss(ss), .lr(lr),
        .c0(c0), .c1(c1), .s0(s0), .s1(s1),
        .run(run[0]), .clr(clr[0]),
        .d0(dsp[0][3:0]), .d1(dsp[0][7:4]), .d2(dsp[0][11:8]), .d3(dsp[0][15:12]),
        .lap(lap[0])
    );

    chrono_ctrl #(.LAP_EN(1'b0)) dut_nolap (
        .ck(ck), .cl(cl), .ss(ss), .lr(lr),
        .c0(c0), .c1(c1), .s0(s0), .s1(s1),
        .run(run[1]), .clr(clr[1]),
        .d0(dsp[1][3:0]), .d1(dsp[1][7:4]), .d2(dsp[1][11:8]), .d3(dsp[1][15:12]),
        .lap(lap[1])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit sp, lp;
        sp = ss & ~m_ssq;
        lp = lr & ~m_lrq;
        for (int k = 0; k < 2; k++) begin
            if (cl) begin
                m_idle[k] = 1'b1; m_cnt[k] = 1'b0; m_frz[k] = 1'b0; m_disp[k] = '0;
            end else begin
                if (!m_frz[k]) m_disp[k] = {s1, s0, c1, c0};
                if (sp) begin
                    if (m_idle[k]) begin m_idle[k] = 1'b0; m_cnt[k] = 1'b1; end
                    else m_cnt[k] = ~m_cnt[k];
                end else if (lp) begin
                    if (m_cnt[k]) begin
                        if (k == 0) m_frz[k] = ~m_frz[k];
                    end else if (m_frz[k]) m_frz[k] = 1'b0;
                    else m_idle[k] = 1'b1;
                end
            end
        end
        m_ssq = cl ? 1'b1 : ss;
        m_lrq = cl ? 1'b1 : lr;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("run%0d", k), 16'(run[k]), 16'(m_cnt[k]));
            check($sformatf("clr%0d", k), 16'(clr[k]), 16'(m_idle[k]));
            check($sformatf("lap%0d", k), 16'(lap[k]), 16'(m_frz[k]));
            check($sformatf("disp%0d", k), dsp[k], m_disp[k]);
        end
    endtask

    task automatic step(input logic i_ss, input logic i_lr, input logic i_cl);
        ss = i_ss; lr = i_lr; cl = i_cl;
        model_edge();
        @(posedge ck);
        #1;
        check_all();
    endtask

    task automatic set_dig(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        s1 = a; s0 = b; c1 = c; c0 = d;
    endtask

    initial begin
        // reset with start/stop held: no press on release
        step(1, 0, 1);
        step(1, 0, 1);
        check("rst_disp", dsp[0], 16'h0000);
        check("rst_clr", 16'(clr[0]), 16'h1);
        step(1, 0, 0);
        check("held_no_press", 16'(run[0]), 16'h0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("start_run", 16'(run[0]), 16'h1);
        check("start_clr", 16'(clr[0]), 16'h0);
        step(1, 0, 0);
        step(1, 0, 0);

        // lap freeze at 43.21 while the datapath advances
        set_dig(4, 3, 2, 1);
        step(0, 0, 0);
        step(0, 1, 0);
        check("lap_on", 16'(lap[0]), 16'h1);
        check("lap_frozen", dsp[0], 16'h4321);
        check("nolap_run", 16'(run[1]), 16'h1);
        check("nolap_lap", 16'(lap[1]), 16'h0);
        set_dig(5, 6, 7, 8);
        step(0, 1, 0);
        check("lap_hold", dsp[0], 16'h4321);
        step(0, 0, 0);
        step(0, 1, 0);
        check("lap_off", 16'(lap[0]), 16'h0);
        step(0, 0, 0);
        check("track_resume", dsp[0], 16'h5678);

        // stop then reset-to-idle
        step(1, 0, 0);
        check("stop_run", 16'(run[0]), 16'h0);
        set_dig(0, 0, 0, 0);
        step(0, 1, 0);
        check("idle_clr", 16'(clr[0]), 16'h1);
        step(0, 0, 0);
        check("idle_zero", dsp[0], 16'h0000);

        // LAP <-> LAPSTOP round trip
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("lapstop_run", 16'(run[0]), 16'h0);
        check("lapstop_lap", 16'(lap[0]), 16'h1);
        step(0, 0, 0);
        step(1, 0, 0);
        check("relap_run", 16'(run[0]), 16'h1);
        step(0, 1, 0);
        check("back_run_lap", 16'(lap[0]), 16'h0);

        // simultaneous presses from RUN: start/stop wins
        step(0, 0, 0);
        step(1, 1, 0);
        check("simul_run", 16'(run[0]), 16'h0);
        check("simul_lap", 16'(lap[0]), 16'h0);

        // reset in LAPSTOP with 12.34 frozen
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        set_dig(1, 2, 3, 4);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("ls_frozen", dsp[0], 16'h1234);
        step(0, 0, 0);
        step(1, 1, 1);
        check("cl_disp", dsp[0], 16'h0000);
        check("cl_lap", 16'(lap[0]), 16'h0);
        check("cl_clr", 16'(clr[0]), 16'h1);
        step(0, 0, 0);

        // random presses, digits and occasional reset
        for (int n = 0; n < 600; n++) begin
            logic nss, nlr, ncl;
            nss = ($urandom_range(0, 3) == 0) ? ~ss : ss;
            nlr = ($urandom_range(0, 3) == 0) ? ~lr : lr;
            ncl = ($urandom_range(0, 80) == 0);
            set_dig(4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
            step(nss, nlr, ncl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
